hs_link_arbiter: RTL and testbench

Round-robin arbiter and four-phase sequencer that shares one clock-domain-crossing handshake link between four send-side requesters. Sits in the `sclk` domain in front of the CDC handshake block. It picks one pending requester, drives `valid`/`data_out` to the link, completes a full four-phase exchange against the receiver's `ack`, and then pulses `done` back to the winner. All outputs are registered; `ack` is synchronised internally.

---
 rtl/hs_link_arbiter.sv | 123 ++++++++++++
 tb/tb_hs_link_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_link_arbiter.sv
// Round-robin arbiter plus four-phase sequencer sharing one CDC handshake link among four requesters.
// Latency: grant one edge after req is sampled in IDLE; done one edge after the synchronised ack falls.
// Backpressure: the receiver's ack paces everything; requesters hold req until done, with no timeout.
module hs_link_arbiter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               sclk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] data_in,
    input  logic               ack,
    output logic               valid,
    output logic [WIDTH-1:0]   data_out,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic [3:0]         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [1:0]             ptr, ptr_d;
    logic [1:0]             win, cand;
    logic                   found;
    logic                   valid_d, busy_d;
    logic [WIDTH-1:0]       data_d;
    logic [1:0]             grant_d;
    logic [3:0]             done_d;

    // ack crosses from the link domain; only the last flop feeds the FSM
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Rotated-priority pick: scan ptr+1 .. ptr+4, first pending requester wins
    always_comb begin
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    // Next-state and next registered outputs; the done pulse clears itself every cycle
    always_comb begin
        state_d = state;
        valid_d = valid;
        data_d  = data_out;
        grant_d = grant_id;
        busy_d  = busy;
        done_d  = '0;
        ptr_d   = ptr;
        case (state)
            IDLE: begin
                // A stale ack left over from a previous exchange blocks new grants
                if (found && !ack_s) begin
                    data_d  = data_in[int'(win)*WIDTH +: WIDTH];
                    grant_d = win;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    valid_d = 1'b0;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!ack_s) begin
                    done_d[grant_id] = 1'b1;
                    ptr_d            = grant_id;
                    busy_d           = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and all outputs registered together
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            valid    <= 1'b0;
            data_out <= '0;
            grant_id <= 2'd0;
            busy     <= 1'b0;
            done     <= '0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            valid    <= valid_d;
            data_out <= data_d;
            grant_id <= grant_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_hs_link_arbiter.sv
// Self-checking bench for hs_link_arbiter: transaction-level model compared every cycle,
// plus literal expectations for each directed scenario.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_hs_link_arbiter;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;

    logic        sclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] data_in = '0;
    logic        ack;
    logic        valid;
    logic [3:0]  data_out;
    logic [1:0]  grant_id;
    logic        busy;
    logic [3:0]  done;

    logic link_auto = 1'b1;
    logic ack_man   = 1'b0;
    logic ack_link  = 1'b0;
    int   link_cnt  = 0;

    int vectors     = 0;
    int miscompares = 0;

    assign ack = link_auto ? ack_link : ack_man;

    always #5 sclk = ~sclk;

    hs_link_arbiter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .sclk     (sclk),
        .reset_n  (reset_n),
        .req      (req),
        .data_in  (data_in),
        .ack      (ack),
        .valid    (valid),
        .data_out (data_out),
        .grant_id (grant_id),
        .busy     (busy),
        .done     (done)
    );

    // Link receiver: mirrors valid onto ack six cycles after every change of valid
    always @(negedge sclk) begin
        if (!reset_n) begin
            ack_link = 1'b0;
            link_cnt = 0;
        end else if (valid !== ack_link) begin
            link_cnt++;
            if (link_cnt >= 6) begin
                ack_link = valid;
                link_cnt = 0;
            end
        end else begin
            link_cnt = 0;
        end
    end

    // Transaction model: one transfer at a time, ack seen SYNC edges late
    bit       m_busy, m_acked, m_valid, ack_seen;
    int       m_id, m_last;
    logic [3:0] m_word, m_done;
    bit       ack_hist[$];

    always @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_acked = 0; m_valid = 0;
            m_id = 0; m_last = 3; m_word = '0; m_done = '0;
            ack_hist.delete();
        end else begin
            ack_seen = (ack_hist.size() >= SYNC) ? ack_hist[ack_hist.size()-SYNC] : 1'b0;
            ack_hist.push_back(ack);
            if (ack_hist.size() > 8) void'(ack_hist.pop_front());
            m_done = '0;
            if (!m_busy) begin
                if (req != 4'd0 && !ack_seen) begin
                    for (int k = 1; k <= 4; k++) begin
                        int c;
                        c = (m_last + k) % 4;
                        if (req[c]) begin
                            m_id   = c;
                            m_word = data_in[c*4 +: 4];
                            break;
                        end
                    end
                    m_busy = 1; m_acked = 0; m_valid = 1;
                end
            end else if (!m_acked) begin
                if (ack_seen) begin
                    m_acked = 1;
                    m_valid = 0;
                end
            end else if (!ack_seen) begin
                m_busy = 0;
                m_done = 4'd1 << m_id;
                m_last = m_id;
            end
        end
    end

    // Every-cycle comparison against the model, plus grant/done logging
    logic [3:0] grant_q[$];
    logic [3:0] done_q[$];
    logic       prev_valid = 1'b0;

    always @(posedge sclk) begin
        #1;
        if (reset_n) begin
            vectors++;
            if (valid !== m_valid || data_out !== m_word || grant_id !== 2'(m_id) ||
                busy !== m_busy || done !== m_done) begin
                miscompares++;
                $display("FAIL cycle t=%0t: got v=%b d=%h g=%0d b=%b done=%b, want v=%b d=%h g=%0d b=%b done=%b",
                         $time, valid, data_out, grant_id, busy, done,
                         m_valid, m_word, m_id, m_busy, m_done);
            end
            if (valid && !prev_valid) grant_q.push_back(data_out);
            if (done != 4'd0) done_q.push_back(done);
            prev_valid = valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(output logic [3:0] d);
        bit got;
        got = 0;
        d   = '0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge sclk); #1;
            if (done != 4'd0) begin
                d   = done;
                got = 1;
            end
        end
        if (!got) chk("wait_done timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit got;
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge sclk); #1;
            if (valid) got = 1;
        end
        if (!got) chk("wait_valid timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge sclk);
        reset_n = 1'b0;
        repeat (2) @(negedge sclk);
        reset_n = 1'b1;
    endtask

    function automatic int qget(input int idx, input bit use_done);
        if (use_done) return (done_q.size() > idx) ? int'(done_q[idx]) : -1;
        return (grant_q.size() > idx) ? int'(grant_q[idx]) : -1;
    endfunction

    initial begin
        logic [3:0] d;
        int n;

        // Reset state
        #2;
        chk("reset valid", int'(valid), 0);
        chk("reset data_out", int'(data_out), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);

        // Single requester 2
        do_reset();
        req = 4'b0100; data_in = 16'h0900;
        @(posedge sclk); #1;
        chk("single grant_id", int'(grant_id), 2);
        chk("single data_out", int'(data_out), 9);
        chk("single valid", int'(valid), 1);
        wait_done(d);
        chk("single done", int'(d), 4'b0100);
        @(negedge sclk); req = 4'b0000;
        @(posedge sclk); #1;
        chk("single busy after", int'(busy), 0);
        repeat (20) @(posedge sclk);
        chk("single done count", done_q.size(), 1);

        // All four requesting from reset: order 0,1,2,3
        do_reset();
        grant_q.delete(); done_q.delete();
        req = 4'b1111; data_in = 16'h8421;
        for (int i = 0; i < 4; i++) begin
            wait_done(d);
            @(negedge sclk); req = req & ~d;
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("all4 done[%0d]", i), qget(i, 1), 1 << i);
            chk($sformatf("all4 data[%0d]", i), qget(i, 0), 1 << i);
        end

        // Fairness: 1 held after its done while 3 pending -> 1,3,1
        grant_q.delete(); done_q.delete();
        @(negedge sclk); req = 4'b1010;
        wait_done(d);
        chk("fair first", int'(d), 4'b0010);
        wait_done(d);
        chk("fair second", int'(d), 4'b1000);
        @(negedge sclk); req[3] = 1'b0;
        wait_done(d);
        chk("fair third", int'(d), 4'b0010);
        @(negedge sclk); req = 4'b0000;
        repeat (3) @(negedge sclk);

        // Stale ack blocks grants until it drops
        link_auto = 1'b0; ack_man = 1'b1;
        repeat (SYNC + 1) @(negedge sclk);
        req = 4'b0001; data_in = 16'h8425;
        for (int i = 0; i < 6; i++) begin
            @(posedge sclk); #1;
            chk("stale valid low", int'(valid), 0);
        end
        @(negedge sclk); ack_man = 1'b0;
        n = 0;
        while (!valid && n < 12) begin
            @(posedge sclk); #1;
            n++;
        end
        chk("stale release latency", n, SYNC + 1);
        chk("stale data_out", int'(data_out), 5);
        @(negedge sclk); link_auto = 1'b1;
        wait_done(d);
        chk("stale done", int'(d), 4'b0001);
        @(negedge sclk); req = 4'b0000;
        repeat (3) @(negedge sclk);

        // Reset while in REQ
        req = 4'b0001; data_in = 16'h842F;
        wait_valid();
        chk("midreset data before", int'(data_out), 15);
        @(negedge sclk); reset_n = 1'b0;
        #1;
        chk("midreset valid", int'(valid), 0);
        chk("midreset data_out", int'(data_out), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset grant_id", int'(grant_id), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge sclk); #1;
            chk("midreset no done", int'(done), 0);
        end
        @(negedge sclk);
        grant_q.delete(); done_q.delete();
        data_in = 16'h8421; req = 4'b1111; reset_n = 1'b1;
        wait_done(d);
        chk("post-reset first done", int'(d), 4'b0001);
        chk("post-reset first data", qget(0, 0), 1);
        @(negedge sclk); req = 4'b0000;
        repeat (20) @(negedge sclk);

        // Input changes during transfer are ignored
        grant_q.delete(); done_q.delete();
        req = 4'b0001; data_in = 16'h8426;
        wait_valid();
        @(negedge sclk); req = 4'b0000; data_in = 16'h8420;
        wait_done(d);
        chk("change done", int'(d), 4'b0001);
        chk("change data held", int'(data_out), 6);
        chk("change grant data", qget(0, 0), 6);
        repeat (20) @(posedge sclk);
        chk("change done count", done_q.size(), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
